// File: rtl/banked_mem_model.sv
// banked_mem_model
// ----------------
// Multi-channel, word-addressed simulation/FPGA memory. NUM_CH requesters share
// one storage array. A round-robin arbiter grants one request at a time. Each
// grant completes LATENCY cycles later with a single-cycle resp pulse to the
// granted channel. Every completion is followed by one idle cycle before the
// next grant.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous, active-high reset
//   read         per-channel read request
//   write        per-channel write request (wins over read when both are set)
//   byte_enable  per-channel write byte mask, channel c at [c*BE_W +: BE_W]
//   address      per-channel byte address, channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata        per-channel write data, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   resp         per-channel one-cycle completion pulse
//   rdata        per-channel read data, held until that channel's next read
//   err          sticky per-channel protocol-violation flag

module banked_mem_model #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned BE_W       = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            read,
    input  logic [NUM_CH-1:0]            write,
    input  logic [NUM_CH*BE_W-1:0]       byte_enable,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] address,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
    output logic [NUM_CH-1:0]            resp,
    output logic [NUM_CH*DATA_WIDTH-1:0] rdata,
    output logic [NUM_CH-1:0]            err
);

    localparam int unsigned OFF   = (BE_W > 1) ? $clog2(BE_W) : 0;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    // Channel-indexed views of the flat port vectors.
    logic [ADDR_WIDTH-1:0] addr_a  [NUM_CH];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_CH];
    logic [BE_W-1:0]       be_a    [NUM_CH];
    logic [NUM_CH-1:0]     pending;

    // Storage, intentionally not reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      gnt_q, gnt_d;
    logic                  wr_q, wr_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NUM_CH-1:0]     resp_q, resp_d;
    logic [DATA_WIDTH-1:0] rdata_q [NUM_CH];
    logic [DATA_WIDTH-1:0] rdata_d [NUM_CH];
    logic [NUM_CH-1:0]     err_q, err_d;
    logic                  commit_wr;

    assign pending = read | write;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        assign addr_a[c]  = address[c*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[c] = wdata[c*DATA_WIDTH +: DATA_WIDTH];
        assign be_a[c]    = byte_enable[c*BE_W +: BE_W];
        assign rdata[c*DATA_WIDTH +: DATA_WIDTH] = rdata_q[c];
    end

    assign resp = resp_q;
    assign err  = err_q;

    always_comb begin
        logic             found;
        logic [PTR_W-1:0] cand;
        logic [PTR_W-1:0] gsel;

        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        wr_d      = wr_q;
        be_d      = be_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        resp_d    = '0;
        rdata_d   = rdata_q;
        commit_wr = 1'b0;
        // Simultaneous read and write is flagged in any cycle, granted or not.
        err_d     = err_q | (read & write);

        // First pending channel at or after the round-robin pointer.
        found = 1'b0;
        cand  = '0;
        gsel  = ptr_q;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % int'(NUM_CH));
            if (!found && pending[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d   = gsel;
                    wr_d    = write[gsel];
                    be_d    = be_a[gsel];
                    addr_d  = addr_a[gsel];
                    idx_d   = IDX_W'(addr_a[gsel] >> OFF);
                    wdata_d = wdata_a[gsel];
                    if (int'(gsel) == int'(NUM_CH) - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gsel + 1'b1;
                    end
                    cnt_d   = CNT_W'(1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // The granted requester must hold its request until resp.
                if (!pending[gnt_q] || (addr_a[gnt_q] != addr_q)) begin
                    err_d[gnt_q] = 1'b1;
                end
                if (cnt_q == CNT_W'(LATENCY)) begin
                    if (wr_q) begin
                        commit_wr = 1'b1;
                    end else begin
                        rdata_d[gnt_q] = mem[idx_q];
                    end
                    resp_d[gnt_q] = 1'b1;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                // The extra idle state keeps a just-served request from being regranted.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            err_q   <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                rdata_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Byte-masked write port. A reset aborts the FSM, so an uncommitted write is dropped.
    always_ff @(posedge clk) begin
        if (commit_wr && !rst) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be_q[b]) begin
                    mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_banked_mem_model.sv
// Self-checking bench for banked_mem_model with default parameters
// (2 channels, 16-bit words, 16-bit byte addresses, 1024 words, latency 4).
module tb_banked_mem_model;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_v;
    logic [1:0]  wr_v;
    logic [3:0]  be_v;
    logic [31:0] addr_v;
    logic [31:0] wd_v;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [1:0]  err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] exp_mem [int];
    logic [15:0] exp_rdata [2];
    logic [1:0]  exp_err;
    int          rr_next;

    banked_mem_model dut (
        .clk        (clk),
        .rst        (rst),
        .read       (rd_v),
        .write      (wr_v),
        .byte_enable(be_v),
        .address    (addr_v),
        .wdata      (wd_v),
        .resp       (resp),
        .rdata      (rdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % 1024;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [1:0] be,
                                        input logic [15:0] d);
        logic [15:0] w;
        w = exp_mem.exists(widx(a)) ? exp_mem[widx(a)] : 16'h0000;
        if (be[0]) w[7:0] = d[7:0];
        if (be[1]) w[15:8] = d[15:8];
        exp_mem[widx(a)] = w;
    endfunction

    // Drives one request on a channel (DUT idle) and waits a bounded time for resp.
    task automatic do_xact(input int ch, input bit rd, input bit wr, input logic [1:0] be,
                           input logic [15:0] addr, input logic [15:0] data,
                           output logic [15:0] got, output int lat, output bit stray);
        @(negedge clk);
        rd_v[ch] = rd;
        wr_v[ch] = wr;
        be_v[ch*2 +: 2] = be;
        addr_v[ch*16 +: 16] = addr;
        wd_v[ch*16 +: 16] = data;
        lat = -1;
        stray = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (resp[1-ch]) stray = 1'b1;
            if (resp[ch]) begin
                lat = i;
                break;
            end
        end
        got = rdata[ch*16 +: 16];
        @(negedge clk);
        rd_v[ch] = 1'b0;
        wr_v[ch] = 1'b0;
        rr_next = (ch + 1) % 2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("FAIL reset_resp: got %b want 00", resp);
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0", rdata);
        end
        checks++;
        if (err !== 2'b00) begin
            errors++;
            $display("FAIL reset_err: got %b want 00", err);
        end
        @(negedge clk);
        rst = 1'b0;
        rr_next = 0;
        exp_err = 2'b00;
        exp_rdata[0] = 16'h0;
        exp_rdata[1] = 16'h0;
    endtask

    task automatic test_basic();
        logic [15:0] got;
        int lat;
        bit stray;
        do_xact(0, 1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, got, lat, stray);
        model_write(16'h0010, 2'b11, 16'hBEEF);
        checks++;
        if (lat !== L + 1) begin
            errors++;
            $display("FAIL basic_wr_latency: got %0d want %0d", lat, L + 1);
        end
        do_xact(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, got, lat, stray);
        exp_rdata[0] = exp_mem[widx(16'h0010)];
        checks++;
        if (lat !== L + 1) begin
            errors++;
            $display("FAIL basic_rd_latency: got %0d want %0d", lat, L + 1);
        end
        checks++;
        if (got !== 16'hBEEF) begin
            errors++;
            $display("FAIL basic_rdata: got %h want BEEF", got);
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL basic_resp1: got stray resp1 %b want 0", stray);
        end
        checks++;
        if (err !== 2'b00) begin
            errors++;
            $display("FAIL basic_err: got %b want 00", err);
        end
    endtask

    task automatic test_byte_enable();
        logic [15:0] got;
        int lat;
        bit stray;
        do_xact(0, 1'b0, 1'b1, 2'b11, 16'h0020, 16'h1234, got, lat, stray);
        model_write(16'h0020, 2'b11, 16'h1234);
        do_xact(0, 1'b0, 1'b1, 2'b10, 16'h0020, 16'hAB00, got, lat, stray);
        model_write(16'h0020, 2'b10, 16'hAB00);
        do_xact(1, 1'b1, 1'b0, 2'b00, 16'h0021, 16'h0000, got, lat, stray);
        exp_rdata[1] = exp_mem[widx(16'h0021)];
        checks++;
        if (got !== 16'hAB34) begin
            errors++;
            $display("FAIL be_merge: got %h want AB34", got);
        end
        // byte_enable=0 completes but changes nothing
        do_xact(1, 1'b0, 1'b1, 2'b00, 16'h0020, 16'hFFFF, got, lat, stray);
        checks++;
        if (lat !== L + 1) begin
            errors++;
            $display("FAIL be_zero_latency: got %0d want %0d", lat, L + 1);
        end
        do_xact(0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, got, lat, stray);
        exp_rdata[0] = exp_mem[widx(16'h0020)];
        checks++;
        if (got !== 16'hAB34) begin
            errors++;
            $display("FAIL be_zero_untouched: got %h want AB34", got);
        end
    endtask

    task automatic test_random();
        logic [15:0] got, a, d;
        logic [1:0] be;
        int lat, ch, w;
        bit stray, wr;
        for (int i = 0; i < 16; i++) begin
            ch = $urandom_range(0, 1);
            a = 16'(16'h0100 + 2 * i);
            d = 16'($urandom);
            do_xact(ch, 1'b0, 1'b1, 2'b11, a, d, got, lat, stray);
            model_write(a, 2'b11, d);
        end
        for (int i = 0; i < 30; i++) begin
            ch = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            w = $urandom_range(0, 15);
            // Random high bits exercise modulo-DEPTH aliasing; bit 0 is ignored.
            a = 16'(16'h0100 + 2 * w + $urandom_range(0, 1) + ($urandom_range(0, 31) << 11));
            d = 16'($urandom);
            be = 2'($urandom_range(0, 3));
            do_xact(ch, !wr, wr, be, a, d, got, lat, stray);
            checks++;
            if (lat !== L + 1 || stray !== 1'b0) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got lat=%0d stray=%b want lat=%0d stray=0",
                         i, lat, stray, L + 1);
            end
            if (wr) begin
                model_write(a, be, d);
                checks++;
                if (got !== exp_rdata[ch]) begin
                    errors++;
                    $display("FAIL rand_wr_rdata_hold[%0d]: ch%0d got %h want %h",
                             i, ch, got, exp_rdata[ch]);
                end
            end else begin
                exp_rdata[ch] = exp_mem[widx(a)];
                checks++;
                if (got !== exp_rdata[ch]) begin
                    errors++;
                    $display("FAIL rand_rdata[%0d]: ch%0d addr %h got %h want %h",
                             i, ch, a, got, exp_rdata[ch]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] got;
        logic [1:0] want;
        int lat, exp_ch, last, n;
        bit stray;
        do_xact(0, 1'b0, 1'b1, 2'b11, 16'h0040, 16'hC0C0, got, lat, stray);
        model_write(16'h0040, 2'b11, 16'hC0C0);
        do_xact(1, 1'b0, 1'b1, 2'b11, 16'h0042, 16'h1A1A, got, lat, stray);
        model_write(16'h0042, 2'b11, 16'h1A1A);
        exp_ch = rr_next;
        last = 0;
        n = 0;
        @(negedge clk);
        addr_v = {16'h0042, 16'h0040};
        rd_v = 2'b11;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            if (resp !== 2'b00) begin
                want = 2'b01 << exp_ch;
                checks++;
                if (resp !== want) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got resp %b want %b", n, resp, want);
                end
                checks++;
                if ((cyc - last) !== ((n == 0) ? L + 1 : L + 2)) begin
                    errors++;
                    $display("FAIL rr_spacing[%0d]: got %0d want %0d", n, cyc - last,
                             (n == 0) ? L + 1 : L + 2);
                end
                exp_rdata[exp_ch] = exp_mem[widx((exp_ch == 0) ? 16'h0040 : 16'h0042)];
                checks++;
                if (rdata[exp_ch*16 +: 16] !== exp_rdata[exp_ch]) begin
                    errors++;
                    $display("FAIL rr_rdata[%0d]: got %h want %h", n,
                             rdata[exp_ch*16 +: 16], exp_rdata[exp_ch]);
                end
                last = cyc;
                n++;
                exp_ch = 1 - exp_ch;
                if (n == 4) begin
                    @(negedge clk);
                    rd_v = 2'b00;
                    break;
                end
            end
        end
        rd_v = 2'b00;
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL rr_timeout: got %0d services want 4", n);
        end
        rr_next = exp_ch;
    endtask

    task automatic test_join();
        logic [15:0] got;
        int lat, t0, t1;
        bit stray;
        do_xact(0, 1'b0, 1'b1, 2'b11, 16'h0050, 16'h0A0A, got, lat, stray);
        model_write(16'h0050, 2'b11, 16'h0A0A);
        do_xact(1, 1'b0, 1'b1, 2'b11, 16'h0052, 16'hB1B1, got, lat, stray);
        model_write(16'h0052, 2'b11, 16'hB1B1);
        t0 = -1;
        t1 = -1;
        @(negedge clk);
        addr_v = {16'h0052, 16'h0050};
        rd_v[1] = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (resp[1]) t1 = cyc;
            if (resp[0]) t0 = cyc;
            @(negedge clk);
            if (cyc == 2) rd_v[0] = 1'b1;
            if (t1 == cyc) rd_v[1] = 1'b0;
            if (t0 == cyc) begin
                rd_v[0] = 1'b0;
                break;
            end
        end
        rd_v = 2'b00;
        exp_rdata[0] = exp_mem[widx(16'h0050)];
        exp_rdata[1] = exp_mem[widx(16'h0052)];
        rr_next = 1;
        checks++;
        if (t1 !== L + 1) begin
            errors++;
            $display("FAIL join_ch1_time: got %0d want %0d", t1, L + 1);
        end
        checks++;
        if (t0 === -1 || (t0 - t1) !== L + 2) begin
            errors++;
            $display("FAIL join_ch0_time: got %0d want %0d", t0, t1 + L + 2);
        end
        checks++;
        if (rdata !== {exp_rdata[1], exp_rdata[0]}) begin
            errors++;
            $display("FAIL join_rdata: got %h want %h", rdata, {exp_rdata[1], exp_rdata[0]});
        end
    endtask

    task automatic test_protocol();
        logic [15:0] got;
        int lat, t;
        bit stray;
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL proto_pre_err: got %b want %b", err, exp_err);
        end
        // read and write together: flagged, serviced as a write
        do_xact(0, 1'b1, 1'b1, 2'b11, 16'h0060, 16'h600D, got, lat, stray);
        model_write(16'h0060, 2'b11, 16'h600D);
        exp_err[0] = 1'b1;
        checks++;
        if (lat !== L + 1 || err !== exp_err) begin
            errors++;
            $display("FAIL proto_rw: got lat=%0d err=%b want lat=%0d err=%b",
                     lat, err, L + 1, exp_err);
        end
        do_xact(1, 1'b1, 1'b0, 2'b00, 16'h0060, 16'h0000, got, lat, stray);
        exp_rdata[1] = exp_mem[widx(16'h0060)];
        checks++;
        if (got !== 16'h600D) begin
            errors++;
            $display("FAIL proto_rw_wrote: got %h want 600D", got);
        end
        // ch1 drops read two cycles after its grant
        t = -1;
        @(negedge clk);
        addr_v[31:16] = 16'h0020;
        rd_v[1] = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            if (resp[1]) begin
                t = cyc;
                break;
            end
            @(negedge clk);
            if (cyc == 2) rd_v[1] = 1'b0;
        end
        rd_v[1] = 1'b0;
        rr_next = 0;
        exp_err[1] = 1'b1;
        exp_rdata[1] = exp_mem[widx(16'h0020)];
        checks++;
        if (t !== L + 1) begin
            errors++;
            $display("FAIL proto_drop_resp: got %0d want %0d", t, L + 1);
        end
        checks++;
        if (rdata[31:16] !== exp_rdata[1]) begin
            errors++;
            $display("FAIL proto_drop_rdata: got %h want %h", rdata[31:16], exp_rdata[1]);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL proto_sticky: got %b want %b", err, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        int lat;
        bit stray, seen;
        do_xact(0, 1'b0, 1'b1, 2'b11, 16'h0030, 16'h0000, got, lat, stray);
        model_write(16'h0030, 2'b11, 16'h0000);
        @(negedge clk);
        addr_v[15:0] = 16'h0030;
        wd_v[15:0] = 16'h5555;
        be_v[1:0] = 2'b11;
        wr_v[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        wr_v[0] = 1'b0;
        checks++;
        if (resp !== 2'b00 || rdata !== 32'h0 || err !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_outputs: got resp=%b rdata=%h err=%b want 00 0 00",
                     resp, rdata, err);
        end
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (resp !== 2'b00) seen = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (L + 3) begin
            @(posedge clk);
            #1;
            if (resp !== 2'b00) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_resp: got resp seen=%b want 0", seen);
        end
        exp_err = 2'b00;
        exp_rdata[0] = 16'h0;
        exp_rdata[1] = 16'h0;
        rr_next = 0;
        do_xact(0, 1'b1, 1'b0, 2'b00, 16'h0030, 16'h0000, got, lat, stray);
        checks++;
        if (lat !== L + 1 || got !== exp_mem[widx(16'h0030)]) begin
            errors++;
            $display("FAIL rstmid_readback: got lat=%0d data=%h want lat=%0d data=%h",
                     lat, got, L + 1, exp_mem[widx(16'h0030)]);
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_v = '0;
        wr_v = '0;
        be_v = '0;
        addr_v = '0;
        wd_v = '0;
        test_reset();
        test_basic();
        test_byte_enable();
        test_random();
        test_round_robin();
        test_join();
        test_protocol();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/banked_mem_model.md
Name: banked_mem_model

Overview:
- Parametrised successor to the single-port 16-bit unified memory used by the core test harness.
- Serves NUM_CH independent requesters (e.g. I-side and D-side) from one word-addressed storage array.
- Provides round-robin arbitration, programmable response latency, byte-enabled writes and sticky per-channel protocol-violation flags.
- Sits between the core's cache/fetch interfaces and the backing store in simulation and FPGA builds.

Parameters:
- NUM_CH, 2, number of requester channels (≥1)
- DATA_WIDTH, 16, word width in bits (multiple of 8)
- ADDR_WIDTH, 16, byte-address width
- DEPTH, 1024, storage words (power of 2)
- LATENCY, 4, cycles from grant edge to resp (≥1)
- BE_W, DATA_WIDTH/8, derived byte-enable width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- read  in  NUM_CH  per-channel read request
- write  in  NUM_CH  per-channel write request
- byte_enable  in  NUM_CH*BE_W  per-channel write byte mask, channel c at [c*BE_W +: BE_W]
- address  in  NUM_CH*ADDR_WIDTH  per-channel byte address
- wdata  in  NUM_CH*DATA_WIDTH  per-channel write data
- resp  out  NUM_CH  per-channel one-cycle completion pulse
- rdata  out  NUM_CH*DATA_WIDTH  per-channel read data
- err  out  NUM_CH  sticky protocol-violation flag

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values: resp=0, rdata=0, err=0, FSM=IDLE, RR pointer selects ch0 first.
- Storage array is not cleared by reset; power-up contents are undefined.
- Word index = address[ADDR_WIDTH-1:log2(BE_W)] modulo DEPTH. Low log2(BE_W) address bits are ignored.
- Channel pending = read|write. Requester holds read/write, address, wdata and byte_enable stable until its resp.
- FSM states:
  - IDLE: at the rising edge where ≥1 channel is pending, grant the first pending channel at or after the RR pointer. Latch that channel's request, set pointer = grant+1 (mod NUM_CH), go to BUSY. This is grant edge T.
  - BUSY: count cycles. At edge T+LATENCY, commit the access, assert resp[grant] and go to RESP. With LATENCY=1 the commit happens at T+1.
  - RESP: resp[grant]=1 for exactly this cycle. Next edge: resp=0, go to IDLE.
  - A new grant is possible at the earliest one edge after leaving RESP. This leaves one idle cycle, so a stale request is never regranted.
- Read commit: rdata[grant] ← array[index], valid in the resp cycle. Each channel's rdata holds its value until that channel's next read commit.
- Write commit: for each byte b with byte_enable[b]=1, write array byte b from wdata. Bytes with byte_enable[b]=0 are untouched. Write commit does not change rdata. byte_enable=0 still completes with resp and modifies nothing.
- Requests are serviced strictly one at a time, so there are no cross-channel read/write hazards.
- Non-granted pending channels wait with resp=0 and no time limit.
- A channel waiting through a full grant cycle of another channel is served next.
- err[c] is set (sticky until rst) when any of the following occurs:
  - read[c]&write[c] in any cycle. The request is still serviced as a write.
  - Channel c is granted and its request drops, or its address changes, before its resp edge. The latched request completes anyway.
- Async reset mid-operation: FSM returns to IDLE immediately. An uncommitted write is discarded and no resp is issued for it.

Test Plan:
- LATENCY=4, ch0 writes 0xBEEF to address 0x0010 with be=2'b11, then reads 0x0010 → resp0 rises exactly 4 cycles after each grant edge; rdata0=0xBEEF; resp1 and err stay 0.
- Byte enable: write 0x1234 to 0x0020, then write 0xAB00 with be=2'b10 → read returns 0xAB34. Address 0x0021 aliases the same word.
- ch0 and ch1 reads asserted in the same cycle, held continuously → grants alternate ch0, ch1, ch0, ch1, each resp a single-cycle pulse with one idle cycle between services.
- ch1 alone pending, then ch0 joins while ch1 is busy → ch1 completes, then ch0 is granted. Neither channel starves; ch1's rdata is unchanged by ch0's completion.
- Protocol: ch0 asserts read and write together; separately ch1 drops read 2 cycles after grant → err0=1 and err1=1, both held until rst. The access still completes with resp.
- Reset: assert rst 2 cycles into a LATENCY=4 write of 0x5555 over an existing 0x0000 → resp never fires, readback gives 0x0000, and all outputs are 0 during rst.
